// File: rtl/ram512_stream_loader.sv
// Stream loader for RAM512. A fill command writes a run of consecutive words
// taken from a valid/ready input stream. A dump command reads a run of words
// and sends them out through one registered valid/ready output stage.
// Addresses wrap modulo the RAM depth.
module ram512_stream_loader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out
);

    typedef enum logic [1:0] {IDLE, FILL, DUMP, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   REM_ONE  = 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              done_q, done_d;

    logic fill_beat;
    logic capture;

    // A fill beat writes the RAM on the same edge that moves the address forward.
    // A dump capture loads the output register whenever that register is free or is being drained.
    assign fill_beat = (state_q == FILL) && s_valid;
    assign capture   = (state_q == DUMP) && (!m_valid_q || m_ready);

    // Next-state logic: command decode, address/remaining-count stepping, output register.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_base;
                    rem_d  = cmd_len;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = cmd_write ? FILL : DUMP;
                    end
                end
            end
            FILL: begin
                if (fill_beat) begin
                    addr_d = addr_q + ADDR_ONE;
                    rem_d  = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            DUMP: begin
                if (capture) begin
                    m_data_d  = ram_out;
                    m_valid_d = 1'b1;
                    addr_d    = addr_q + ADDR_ONE;
                    rem_d     = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                    done_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register. Reset drops any command in flight but leaves the RAM contents alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            done_q    <= done_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign s_ready     = (state_q == FILL);
    assign done        = done_q;
    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign ram_load    = fill_beat && !reset;
    assign ram_address = addr_q;
    assign ram_in      = s_data;

endmodule

// File: tb/tb_ram512_stream_loader.sv
// Bench for ram512_stream_loader. It contains a behavioural RAM512 model.
// Dump expectations go into a queue when a command is issued.
// Each entry is popped and compared on the matching output handshake.
module tb_ram512_stream_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [8:0]  cmd_base;
    logic [9:0]  cmd_len;
    logic [15:0] s_data;
    logic        s_valid, s_ready;
    logic [15:0] m_data;
    logic        m_valid, m_ready;
    logic        busy, done;
    logic        ram_load;
    logic [8:0]  ram_address;
    logic [15:0] ram_in, ram_out;

    logic [15:0] ram_mem [0:511];
    logic [15:0] shadow  [0:511];
    logic [15:0] fw      [0:15];
    logic [15:0] exp_q   [$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram512_stream_loader #(.ADDR_W(9), .DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done),
        .ram_load(ram_load), .ram_address(ram_address),
        .ram_in(ram_in), .ram_out(ram_out)
    );

    // RAM512 model: synchronous write, combinational read
    always @(posedge clk) if (ram_load) ram_mem[ram_address] <= ram_in;
    assign ram_out = ram_mem[ram_address];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_fill(input int base, input int len, input bit hog_cmd, input bit stall);
        int addr;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_base = 9'(base); cmd_len = 10'(len);
        @(negedge clk);
        chk("fill_cmd_ready", cmd_ready, 1);
        step();
        if (hog_cmd) begin
            cmd_write = 1'b0; cmd_len = 10'd7; cmd_base = 9'd300;
        end else begin
            cmd_valid = 1'b0;
        end
        for (int i = 0; i < len; i++) begin
            if (stall && i == 2) begin
                s_valid = 1'b0; s_data = 16'hDEAD;
                @(negedge clk);
                chk("fill_stall_load", ram_load, 0);
                chk("fill_stall_ready", s_ready, 1);
                step();
            end
            s_valid = 1'b1; s_data = fw[i];
            if (i == len - 1) cmd_valid = 1'b0;
            addr = (base + i) % 512;
            @(negedge clk);
            chk("fill_load", ram_load, 1);
            chk("fill_addr", ram_address, addr);
            chk("fill_s_ready", s_ready, 1);
            if (hog_cmd) chk("busy_cmd_ready", cmd_ready, 0);
            shadow[addr] = fw[i];
            step();
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk("fill_done", done, 1);
        chk("fill_done_busy", busy, 0);
        step();
        @(negedge clk);
        chk("fill_done_pulse", done, 0);
        $display("fill base=%0d len=%0d hog=%0d stall=%0d", base, len, hog_cmd, stall);
        step();
    endtask

    task automatic do_dump(input int base, input int len, input bit toggle);
        bit          got_done;
        bit          hold_pending;
        logic [15:0] held;
        for (int i = 0; i < len; i++) exp_q.push_back(shadow[(base + i) % 512]);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_base = 9'(base); cmd_len = 10'(len);
        m_ready = 1'b0;
        @(negedge clk);
        chk("dump_cmd_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        got_done = 1'b0;
        hold_pending = 1'b0;
        held = '0;
        for (int c = 0; c < 200 && !got_done; c++) begin
            m_ready = toggle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            @(negedge clk);
            if (c == 0) chk("dump_lat0", m_valid, 0);
            if (c == 1) chk("dump_first_valid", m_valid, 1);
            if (hold_pending) begin
                chk("dump_hold_valid", m_valid, 1);
                chk("dump_hold_data", m_data, held);
            end
            hold_pending = m_valid && !m_ready;
            held = m_data;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("dump_extra_word", m_data, 32'hFFFF_FFFF);
                else chk("dump_data", m_data, exp_q.pop_front());
            end
            if (done) begin
                got_done = 1'b1;
                chk("dump_done_busy", busy, 0);
            end
            step();
        end
        m_ready = 1'b0;
        chk("dump_done_seen", got_done, 1);
        chk("dump_all_words", exp_q.size(), 0);
        exp_q.delete();
        $display("dump base=%0d len=%0d toggle=%0d", base, len, toggle);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            ram_mem[i] = 16'h0000;
            shadow[i]  = 16'h0000;
        end
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = '0; cmd_len = '0;
        s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
        step(); step();
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_ram_load", ram_load, 0);
        step();
        reset = 1'b0;
        step();

        // basic fill then dump
        fw[0] = 16'h0AAA; fw[1] = 16'h1BBB; fw[2] = 16'h2CCC; fw[3] = 16'h3DDD;
        do_fill(0, 4, 1'b0, 1'b0);
        do_dump(0, 4, 1'b0);

        // wrap across 511 -> 0, with a busy-time command held and a stall cycle
        fw[0] = 16'h00A0; fw[1] = 16'h00A1; fw[2] = 16'h00A2; fw[3] = 16'h00A3;
        do_fill(510, 4, 1'b1, 1'b1);
        do_dump(510, 4, 1'b0);

        // backpressure on the output stream
        do_dump(0, 4, 1'b1);

        // random data run
        for (int i = 0; i < 10; i++) fw[i] = 16'($urandom);
        do_fill(100, 10, 1'b0, 1'b1);
        do_dump(100, 10, 1'b1);

        // zero-length command
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_base = 9'd5; cmd_len = 10'd0;
        @(negedge clk);
        chk("len0_cmd_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        chk("len0_m_valid", m_valid, 0);
        chk("len0_ram_load", ram_load, 0);
        step();
        @(negedge clk);
        chk("len0_done_pulse", done, 0);
        $display("zero-length command base=5");
        step();

        // reset in the middle of a fill
        for (int i = 0; i < 8; i++) fw[i] = 16'h5000 + 16'(i);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_base = 9'd20; cmd_len = 10'd8;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = fw[i];
            shadow[20 + i] = fw[i];
            step();
        end
        s_data = 16'hBEEF;
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_ram_load", ram_load, 0);
        chk("midrst_m_data", m_data, 0);
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_done", done, 0);
        step();
        reset = 1'b0; s_valid = 1'b0;
        step();
        chk("midrst_no_write", ram_mem[23], 0);
        $display("reset after 3 of 8 fill beats at base=20");
        do_dump(20, 3, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
